reaction_timer_core: RTL
========================

# reaction_timer_core

Parametrised measuring stage of the reaction-timer game. When enabled, it lights one randomly chosen target LED and counts elapsed time in packed BCD until the player sets exactly the matching switch pattern. It then latches the score and reports the outcome: hit, wrong switch, or timeout. It replaces the fixed 4-digit, 8-target timing stage and sits between the top-level game FSM (which drives `en` and consumes `out_state`) and the HEX/LED outputs.

## Interface
- `TICK_DIV`, 50000: `clk` cycles per count tick (1 ms at 50 MHz); ≥2.
- `DIGITS`, 4: BCD digits in the elapsed counter/score; 1..8.
- `NUM_TARGETS`, 8: selectable target LEDs; 2..`SW_WIDTH`.
- `SW_WIDTH`, 10: width of `SW` and `LEDR`.
- `STRICT`, 1: 1 = any non-zero wrong switch pattern ends the round as FAULT; 0 = wrong patterns are ignored.
- `LFSR_SEED`, 16'hACE1: non-zero reset value of the 16-bit LFSR.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: round enable from the game FSM; level-sensitive.
- `SW` in `SW_WIDTH`: player switches, already synchronised upstream.
- `LEDR` out `SW_WIDTH`: one-hot target while TIMING, else 0.
- `elapsed` out 4*`DIGITS`: live packed BCD count, digit 0 in [3:0].
- `score` out 4*`DIGITS`: latched BCD result of the last finished round.
- `done` out 1: one-cycle pulse on entry to HIT, FAULT or TIMEOUT.
- `out_state` out 4: 2 = timing or idle, 3 = hit, 4 = fault, 5 = timeout.

## Operation
- States: IDLE, TIMING, HIT, FAULT, TIMEOUT.
- IDLE:
  - `LEDR` = 0, `elapsed` held at 0, prescaler cleared.
  - On `en`=1, capture `target = lfsr % NUM_TARGETS` and go to TIMING.
- The LFSR runs every cycle, including while `en`=0.
  - 16-bit Fibonacci, taps 16,14,13,11.
  - It is never loaded with 0.
- TIMING:
  - `LEDR` = 1<<`target`.
  - Prescaler counts 0..`TICK_DIV`-1; each wrap increments `elapsed` as a BCD ripple (digit 9 to 0 with carry).
  - Hit: `SW` == `LEDR` → HIT.
  - Fault (only when `STRICT`=1): `SW` ≠ 0 and ≠ `LEDR` → FAULT.
  - Timeout: `elapsed` all 9s and a tick due → TIMEOUT. The counter saturates at all 9s; it never wraps to 0.
  - `en`=0 → IDLE, `score` unchanged, no `done`.
- On entry to HIT, FAULT or TIMEOUT: `score` ← `elapsed` as it was before any same-cycle tick increment; `done` = 1.
- HIT, FAULT and TIMEOUT hold `LEDR` = 0, `elapsed` frozen and `out_state` constant until `en`=0, then go to IDLE.
- Priority within a cycle: hit > fault > timeout > tick.
- Reset values: state IDLE, `LEDR` 0, `elapsed` 0, `score` 0, `done` 0, `out_state` 2, LFSR = `LFSR_SEED`, `target` 0.
  - `rst` has priority over everything, including mid-round.

## Timing
- `en` sampled high at edge N → TIMING registered at N+1, `LEDR` valid at N+1.
- First tick at edge N+1+`TICK_DIV`; `elapsed` = 1 from then on.
- `SW` compared against the registered `LEDR` value.
  - Match sampled at edge M → state, `score`, `done` and `out_state` update at M+1 (one-cycle latency).
- All outputs are registered; no combinational input-to-output path.
- `done` is high for exactly one cycle per finished round.
- Dropping `en` while in a result state returns to IDLE on the next edge.

## Structure
- Shared package:
  - `out_state` codes as localparams: `ST_TIMING`=2, `ST_HIT`=3, `ST_FAULT`=4, `ST_TIMEOUT`=5.
  - State encoding.
  - BCD digit max (4'd9).
- One sub-module, `bcd_counter_chain`:
  - Parameter `DIGITS`; ports `clk`, `rst`, `clr`, `inc`.
  - Outputs packed `q` and `sat` (all 9s).
  - Synchronous increment with saturation.
- Prescaler, LFSR and FSM live in the top module.

## Test plan
- `TICK_DIV`=4, `rst`=1 for 3 cycles then 0 → all outputs at reset values, `out_state`=2.
- `en`↑, set `SW` = `LEDR` after 37 ticks → `score`=16'h0037, `done` one pulse, `out_state`=3, `LEDR`=0.
- `STRICT`=1, wrong single switch after 5 ticks → `out_state`=4, `score`=16'h0005. Same stimulus with `STRICT`=0 → stays TIMING.
- `DIGITS`=2, no response → `elapsed` reaches 8'h99, next tick gives TIMEOUT, `score`=8'h99, `out_state`=5.
- Drop `en` mid-round at `elapsed`=12 → IDLE next cycle, `score` keeps its prior value, no `done`.
- Carry check: 8'h09→8'h10 and 16'h0999→16'h1000 on a single tick.
- 64 rounds with the default seed → every target index 0..`NUM_TARGETS`-1 is hit at least once, and the target is never ≥ `NUM_TARGETS`.

Source files
------------

// File: rtl/reaction_timer_core_pkg.sv
// Shared definitions for the reaction-timer measuring stage: result codes,
// FSM encoding, BCD limits and the LFSR step function.
package reaction_timer_core_pkg;

  localparam logic [3:0] ST_TIMING  = 4'd2;
  localparam logic [3:0] ST_HIT     = 4'd3;
  localparam logic [3:0] ST_FAULT   = 4'd4;
  localparam logic [3:0] ST_TIMEOUT = 4'd5;

  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_TIMING  = 3'd1,
    S_HIT     = 3'd2,
    S_FAULT   = 3'd3,
    S_TIMEOUT = 3'd4
  } state_e;

  // 16-bit Fibonacci LFSR, taps 16,14,13,11; a maximal sequence never reaches 0.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/reaction_timer_core_bcd_counter_chain.sv
// Packed BCD up-counter with ripple carry that saturates at all 9s.
module bcd_counter_chain
  import reaction_timer_core_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                inc,
  output logic [4*DIGITS-1:0] q,
  output logic                sat
);

  logic [4*DIGITS-1:0] q_q;
  logic [4*DIGITS-1:0] q_d;
  logic                carry_s;
  logic                sat_s;

  // Saturation detect and ripple increment of the digit chain.
  always_comb begin
    q_d     = q_q;
    carry_s = 1'b1;
    sat_s   = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      sat_s = sat_s && (q_q[4*i +: 4] == BCD_MAX);
    end
    if (clr) begin
      q_d = {(4*DIGITS){1'b0}};
    end else if (inc && !sat_s) begin
      for (int j = 0; j < DIGITS; j++) begin
        if (carry_s) begin
          if (q_q[4*j +: 4] == BCD_MAX) begin
            q_d[4*j +: 4] = 4'd0;
            carry_s       = 1'b1;
          end else begin
            q_d[4*j +: 4] = q_q[4*j +: 4] + 4'd1;
            carry_s       = 1'b0;
          end
        end else begin
          q_d[4*j +: 4] = q_q[4*j +: 4];
          carry_s       = 1'b0;
        end
      end
    end else begin
      q_d = q_q;
    end
  end

  // Counter state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= {(4*DIGITS){1'b0}};
    end else begin
      q_q <= q_d;
    end
  end

  assign q   = q_q;
  assign sat = sat_s;

endmodule

// File: rtl/reaction_timer_core.sv
// Measuring stage of the reaction-timer game: lights a random target, times
// the player's response in BCD and latches the outcome.
module reaction_timer_core
  import reaction_timer_core_pkg::*;
#(
  parameter int          TICK_DIV    = 50000,
  parameter int          DIGITS      = 4,
  parameter int          NUM_TARGETS = 8,
  parameter int          SW_WIDTH    = 10,
  parameter int          STRICT      = 1,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [SW_WIDTH-1:0] SW,
  output logic [SW_WIDTH-1:0] LEDR,
  output logic [4*DIGITS-1:0] elapsed,
  output logic [4*DIGITS-1:0] score,
  output logic                done,
  output logic [3:0]          out_state
);

  localparam int            PW         = $clog2(TICK_DIV);
  localparam int            TW         = $clog2(NUM_TARGETS);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  state_e              state_q;
  logic [15:0]         lfsr_q;
  logic [TW-1:0]       target_q;
  logic [PW-1:0]       presc_q;
  logic [SW_WIDTH-1:0] ledr_q;
  logic [4*DIGITS-1:0] score_q;
  logic                done_q;
  logic [3:0]          out_state_q;

  logic [4*DIGITS-1:0] elapsed_s;
  logic                sat_s;
  logic                tick_s;
  logic                hit_s;
  logic                fault_s;
  logic                clr_s;
  logic                inc_s;
  logic [TW-1:0]       target_s;

  function automatic logic [SW_WIDTH-1:0] onehot(input logic [TW-1:0] idx);
    return {{(SW_WIDTH-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Round conditions; a hit or fault suppresses the tick so the score is the
  // count as it stood before this edge.
  always_comb begin
    target_s = TW'(lfsr_q % 16'(NUM_TARGETS));
    tick_s   = (state_q == S_TIMING) && (presc_q == PRESC_LAST);
    hit_s    = (state_q == S_TIMING) && (SW == ledr_q);
    fault_s  = (STRICT != 0) && (state_q == S_TIMING) &&
               (SW != {SW_WIDTH{1'b0}}) && (SW != ledr_q);
    clr_s    = (state_q == S_IDLE) || !en;
    inc_s    = en && tick_s && !hit_s && !fault_s;
  end

  bcd_counter_chain #(
    .DIGITS(DIGITS)
  ) u_bcd (
    .clk (clk),
    .rst (rst),
    .clr (clr_s),
    .inc (inc_s),
    .q   (elapsed_s),
    .sat (sat_s)
  );

  // Round FSM with LFSR, prescaler and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      lfsr_q      <= LFSR_SEED;
      target_q    <= {TW{1'b0}};
      presc_q     <= {PW{1'b0}};
      ledr_q      <= {SW_WIDTH{1'b0}};
      score_q     <= {(4*DIGITS){1'b0}};
      done_q      <= 1'b0;
      out_state_q <= ST_TIMING;
    end else begin
      lfsr_q <= lfsr_next(lfsr_q);
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          presc_q     <= {PW{1'b0}};
          out_state_q <= ST_TIMING;
          if (en) begin
            target_q <= target_s;
            ledr_q   <= onehot(target_s);
            state_q  <= S_TIMING;
          end else begin
            ledr_q <= {SW_WIDTH{1'b0}};
          end
        end
        S_TIMING: begin
          if (!en) begin
            state_q <= S_IDLE;
            ledr_q  <= {SW_WIDTH{1'b0}};
            presc_q <= {PW{1'b0}};
          end else if (hit_s) begin
            state_q     <= S_HIT;
            score_q     <= elapsed_s;
            done_q      <= 1'b1;
            out_state_q <= ST_HIT;
            ledr_q      <= {SW_WIDTH{1'b0}};
          end else if (fault_s) begin
            state_q     <= S_FAULT;
            score_q     <= elapsed_s;
            done_q      <= 1'b1;
            out_state_q <= ST_FAULT;
            ledr_q      <= {SW_WIDTH{1'b0}};
          end else if (tick_s && sat_s) begin
            state_q     <= S_TIMEOUT;
            score_q     <= elapsed_s;
            done_q      <= 1'b1;
            out_state_q <= ST_TIMEOUT;
            ledr_q      <= {SW_WIDTH{1'b0}};
          end else if (tick_s) begin
            presc_q <= {PW{1'b0}};
          end else begin
            presc_q <= presc_q + PW'(1);
          end
        end
        S_HIT, S_FAULT, S_TIMEOUT: begin
          ledr_q <= {SW_WIDTH{1'b0}};
          if (!en) begin
            state_q     <= S_IDLE;
            out_state_q <= ST_TIMING;
          end else begin
            state_q <= state_q;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          ledr_q      <= {SW_WIDTH{1'b0}};
          presc_q     <= {PW{1'b0}};
          out_state_q <= ST_TIMING;
        end
      endcase
    end
  end

  assign LEDR      = ledr_q;
  assign elapsed   = elapsed_s;
  assign score     = score_q;
  assign done      = done_q;
  assign out_state = out_state_q;

endmodule
